// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared constants for the ALU sequencer.
//   ALU_*      : operation codes understood by the external ALU.
//   ALU_SEQ_*  : sequencer state encodings and the default settle time.
//   Helpers    : alu_is_legal() / alu_is_shift() classify an operation code.
// Optional feature macro used by alu_seq: ALU_SEQ_MULTISHIFT_EN.
package alu_seq_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLL = 4'h5;
  localparam logic [3:0] ALU_SRL = 4'h6;
  localparam logic [3:0] ALU_SRA = 4'h7;

  localparam int ALU_SEQ_SETTLE_DEFAULT = 2;

  typedef enum logic [2:0] {
    ALU_SEQ_IDLE    = 3'd0,
    ALU_SEQ_ISSUE   = 3'd1,
    ALU_SEQ_CAPTURE = 3'd2,
    ALU_SEQ_RELEASE = 3'd3,
    ALU_SEQ_DONE    = 3'd4
  } alu_seq_state_e;

  function automatic logic alu_is_legal(input logic [3:0] code);
    logic ok;
    case (code)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
      ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic alu_is_shift(input logic [3:0] code);
    logic sh;
    case (code)
      ALU_SLL, ALU_SRL, ALU_SRA: sh = 1'b1;
      default:                   sh = 1'b0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if -- request/result bus plus ALU drive/return bus of alu_seq.
//   Request side : iREQ, iCTRL, iCOUNT, iA, iB   -> sequencer
//   Result side  : oBUSY, oDONE, oERR, oRES, oNEG, oALL_ZEROn, oANY_POS
//   ALU drive    : oALU_ENABLE, oALU_CTRL, oALU_OP1, oALU_OP2
//   ALU return   : iALU_RES, iALU_NEG, iALU_ALL_ZEROn, iALU_ANY_POS
// Modport slave is the sequencer's view; master is the surrounding system
// (requester plus ALU).
interface alu_seq_if;
  logic        iREQ;
  logic [3:0]  iCTRL;
  logic [3:0]  iCOUNT;
  logic [11:0] iA;
  logic [11:0] iB;
  logic        oBUSY;
  logic        oDONE;
  logic        oERR;
  logic [11:0] oRES;
  logic        oNEG;
  logic        oALL_ZEROn;
  logic        oANY_POS;
  logic        oALU_ENABLE;
  logic [3:0]  oALU_CTRL;
  logic [11:0] oALU_OP1;
  logic [11:0] oALU_OP2;
  logic [11:0] iALU_RES;
  logic        iALU_NEG;
  logic        iALU_ALL_ZEROn;
  logic        iALU_ANY_POS;

  modport slave (
    input  iREQ, iCTRL, iCOUNT, iA, iB,
    input  iALU_RES, iALU_NEG, iALU_ALL_ZEROn, iALU_ANY_POS,
    output oBUSY, oDONE, oERR, oRES, oNEG, oALL_ZEROn, oANY_POS,
    output oALU_ENABLE, oALU_CTRL, oALU_OP1, oALU_OP2
  );

  modport master (
    output iREQ, iCTRL, iCOUNT, iA, iB,
    output iALU_RES, iALU_NEG, iALU_ALL_ZEROn, iALU_ANY_POS,
    input  oBUSY, oDONE, oERR, oRES, oNEG, oALL_ZEROn, oANY_POS,
    input  oALU_ENABLE, oALU_CTRL, oALU_OP1, oALU_OP2
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq -- sequencer that drives an external multi-cycle ALU.
// A request is accepted in IDLE; the ALU is enabled for SETTLE cycles
// (ISSUE) plus one CAPTURE cycle, the result is registered, the enable is
// dropped for one RELEASE cycle, and after the last iteration DONE pulses
// oDONE and publishes oRES. Flags follow the ALU only for ALU_SUB. Illegal
// codes skip the ALU and finish with oERR.
// Ports: iCLK, iRESET (sync, active-high), bus (alu_seq_if.slave).
// Parameter: SETTLE (1..15) ALU settle cycles per iteration.
// Optional: `define ALU_SEQ_MULTISHIFT_EN to let shifts repeat iCOUNT times,
// feeding each result back as the next OP2.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int SETTLE = ALU_SEQ_SETTLE_DEFAULT
) (
  input logic       iCLK,
  input logic       iRESET,
  alu_seq_if.slave  bus
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  alu_seq_state_e state_q, state_d;
  logic [3:0]  settle_q, settle_d;
  logic [3:0]  iter_q, iter_d;      // iterations still to run after this one
  logic [3:0]  ctrl_q, ctrl_d;
  logic [11:0] op1_q, op1_d;
  logic [11:0] op2_q, op2_d;
  logic [11:0] work_q, work_d;
  logic        wneg_q, wneg_d;
  logic        wallzn_q, wallzn_d;
  logic        wanypos_q, wanypos_d;
  logic        busy_q, busy_d;
  logic        en_q, en_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [11:0] res_q, res_d;
  logic        neg_q, neg_d;
  logic        allzn_q, allzn_d;
  logic        anypos_q, anypos_d;
  logic        enter_done_s;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    iter_d    = iter_q;
    ctrl_d    = ctrl_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    work_d    = work_q;
    wneg_d    = wneg_q;
    wallzn_d  = wallzn_q;
    wanypos_d = wanypos_q;

    case (state_q)
      ALU_SEQ_IDLE: begin
        if (bus.iREQ) begin
          ctrl_d   = bus.iCTRL;
          op1_d    = bus.iA;
          op2_d    = bus.iB;
          work_d   = bus.iB;   // zero-iteration shifts publish iB unchanged
          settle_d = SETTLE_LAST;
          iter_d   = 4'd0;
          if (!alu_is_legal(bus.iCTRL)) begin
            state_d = ALU_SEQ_DONE;
          end else begin
`ifdef ALU_SEQ_MULTISHIFT_EN
            if (alu_is_shift(bus.iCTRL)) begin
              if (bus.iCOUNT == 4'd0) begin
                state_d = ALU_SEQ_DONE;
              end else begin
                iter_d  = bus.iCOUNT - 4'd1;
                state_d = ALU_SEQ_ISSUE;
              end
            end else begin
              state_d = ALU_SEQ_ISSUE;
            end
`else
            state_d = ALU_SEQ_ISSUE;
`endif
          end
        end else begin
          state_d = ALU_SEQ_IDLE;
        end
      end
      ALU_SEQ_ISSUE: begin
        if (settle_q == 4'd0) begin
          state_d = ALU_SEQ_CAPTURE;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      ALU_SEQ_CAPTURE: begin
        work_d = bus.iALU_RES;
        if (ctrl_q == ALU_SUB) begin
          wneg_d    = bus.iALU_NEG;
          wallzn_d  = bus.iALU_ALL_ZEROn;
          wanypos_d = bus.iALU_ANY_POS;
        end else begin
          wneg_d    = wneg_q;
        end
`ifdef ALU_SEQ_MULTISHIFT_EN
        // Repeated shifts operate on the previous iteration's result.
        if (alu_is_shift(ctrl_q)) begin
          op2_d = bus.iALU_RES;
        end else begin
          op2_d = op2_q;
        end
`endif
        state_d = ALU_SEQ_RELEASE;
      end
      ALU_SEQ_RELEASE: begin
        if (iter_q == 4'd0) begin
          state_d = ALU_SEQ_DONE;
        end else begin
          iter_d   = iter_q - 4'd1;
          settle_d = SETTLE_LAST;
          state_d  = ALU_SEQ_ISSUE;
        end
      end
      ALU_SEQ_DONE: begin
        state_d = ALU_SEQ_IDLE;
      end
      default: begin
        state_d = ALU_SEQ_IDLE;
      end
    endcase

    // Outputs are registered so each one lines up with the state it belongs to.
    enter_done_s = (state_d == ALU_SEQ_DONE);
    busy_d   = (state_d != ALU_SEQ_IDLE);
    en_d     = (state_d == ALU_SEQ_ISSUE) || (state_d == ALU_SEQ_CAPTURE);
    done_d   = enter_done_s;
    err_d    = enter_done_s && !alu_is_legal(ctrl_d);
    res_d    = (enter_done_s && alu_is_legal(ctrl_d)) ? work_d : res_q;
    neg_d    = (enter_done_s && (ctrl_d == ALU_SUB)) ? wneg_d    : neg_q;
    allzn_d  = (enter_done_s && (ctrl_d == ALU_SUB)) ? wallzn_d  : allzn_q;
    anypos_d = (enter_done_s && (ctrl_d == ALU_SUB)) ? wanypos_d : anypos_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q   <= ALU_SEQ_IDLE;
      settle_q  <= 4'd0;
      iter_q    <= 4'd0;
      ctrl_q    <= 4'd0;
      op1_q     <= 12'd0;
      op2_q     <= 12'd0;
      work_q    <= 12'd0;
      wneg_q    <= 1'b0;
      wallzn_q  <= 1'b1;
      wanypos_q <= 1'b0;
      busy_q    <= 1'b0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      res_q     <= 12'd0;
      neg_q     <= 1'b0;
      allzn_q   <= 1'b1;
      anypos_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      iter_q    <= iter_d;
      ctrl_q    <= ctrl_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      work_q    <= work_d;
      wneg_q    <= wneg_d;
      wallzn_q  <= wallzn_d;
      wanypos_q <= wanypos_d;
      busy_q    <= busy_d;
      en_q      <= en_d;
      done_q    <= done_d;
      err_q     <= err_d;
      res_q     <= res_d;
      neg_q     <= neg_d;
      allzn_q   <= allzn_d;
      anypos_q  <= anypos_d;
    end
  end

  assign bus.oBUSY       = busy_q;
  assign bus.oDONE       = done_q;
  assign bus.oERR        = err_q;
  assign bus.oRES        = res_q;
  assign bus.oNEG        = neg_q;
  assign bus.oALL_ZEROn  = allzn_q;
  assign bus.oANY_POS    = anypos_q;
  assign bus.oALU_ENABLE = en_q;
  assign bus.oALU_CTRL   = ctrl_q;
  assign bus.oALU_OP1    = op1_q;
  assign bus.oALU_OP2    = op2_q;

endmodule
